// File: rtl/cpu_pkg.sv
// Shared types for the memory stage: memory-op encoding, pipeline register layouts
// and small decode helpers used by the LSU and its load extender.
package cpu_pkg;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LW   = 4'd1,
        MOP_LH   = 4'd2,
        MOP_LHU  = 4'd3,
        MOP_LB   = 4'd4,
        MOP_LBU  = 4'd5,
        MOP_SW   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SB   = 4'd8
    } mop_e;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        mop_e        mop;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        we;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        mop_e        mop;
        logic [1:0]  off;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } mem_wb_t;

    function automatic logic is_load(input mop_e mop);
        return (mop >= MOP_LW) && (mop <= MOP_LBU);
    endfunction

    function automatic logic is_store(input mop_e mop);
        return (mop >= MOP_SW) && (mop <= MOP_SB);
    endfunction

    // Word ops need a 4-byte aligned address, half ops a 2-byte aligned one.
    function automatic logic is_misaligned(input mop_e mop, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (mop)
            MOP_LW, MOP_SW:          mis = (off != 2'b00);
            MOP_LH, MOP_LHU, MOP_SH: mis = off[0];
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load extender: picks the addressed byte/half out of a read word and sign- or
// zero-extends it; non-byte/half ops pass the word through unchanged.
module load_ext (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [3:0]  mop,
    output logic [31:0] data
);
    import cpu_pkg::*;

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = off[1] ? word[31:16] : word[15:0];
    assign byte_sel = word[{off, 3'b000} +: 8];

    always_comb begin
        data = word;
        case (mop_e'(mop))
            MOP_LH:  data = {{16{half_sel[15]}}, half_sel};
            MOP_LHU: data = {16'h0000, half_sel};
            MOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MOP_LBU: data = {24'h000000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage of the CPU: EX/MEM and MEM/WB registers, data-bus master for loads and
// stores, alignment checking, MEM-stage forwarding and the GRF writeback port.
module mem_stage_lsu #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_mop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic [4:0]  ex_rd,
    input  logic        ex_we,
    input  logic        hold,
    input  logic        flush,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    input  logic [31:0] m_data_rdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        align_err,
    output logic [31:0] err_pc,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr
);
    import cpu_pkg::*;

    ex_mem_t     mem_q, mem_d;
    mem_wb_t     wb_q, wb_d;
    logic        align_err_q, align_err_d;
    logic [31:0] err_pc_q, err_pc_d;

    logic        advance;
    logic        misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ext_data;

    assign advance    = ~hold;
    assign misaligned = mem_q.valid & is_misaligned(mem_q.mop, mem_q.addr[1:0]);

    always_comb begin
        mem_d = mem_q;
        if (advance) begin
            if (flush) begin
                mem_d.valid = 1'b0;
                mem_d.pc    = ex_pc;
                mem_d.mop   = MOP_NONE;
                mem_d.addr  = 32'h0;
                mem_d.sdata = 32'h0;
                mem_d.rd    = 5'd0;
                mem_d.we    = 1'b0;
            end else begin
                mem_d.valid = ex_valid;
                mem_d.pc    = ex_pc;
                mem_d.mop   = mop_e'(ex_mop);
                mem_d.addr  = ex_addr;
                mem_d.sdata = ex_sdata;
                mem_d.rd    = ex_rd;
                mem_d.we    = ex_we;
            end
        end
    end

    // A held MEM stage still lets WB drain, so WB sees a bubble each held cycle.
    always_comb begin
        wb_d.valid = 1'b0;
        wb_d.pc    = RESET_PC;
        wb_d.mop   = MOP_NONE;
        wb_d.off   = 2'b00;
        wb_d.data  = 32'h0;
        wb_d.rd    = 5'd0;
        wb_d.we    = 1'b0;
        if (advance) begin
            wb_d.valid = mem_q.valid;
            wb_d.pc    = mem_q.pc;
            wb_d.mop   = mem_q.mop;
            wb_d.off   = mem_q.addr[1:0];
            wb_d.data  = is_load(mem_q.mop) ? m_data_rdata : mem_q.addr;
            wb_d.rd    = mem_q.rd;
            wb_d.we    = mem_q.we & ~misaligned;
        end
    end

    always_comb begin
        align_err_d = advance & misaligned;
        err_pc_d    = (advance & misaligned) ? mem_q.pc : err_pc_q;
    end

    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = mem_q.sdata;
        case (mem_q.mop)
            MOP_SW: begin
                lane_be    = 4'b1111;
                lane_wdata = mem_q.sdata;
            end
            MOP_SH: begin
                lane_be    = mem_q.addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{mem_q.sdata[15:0]}};
            end
            MOP_SB: begin
                lane_be    = 4'b0001 << mem_q.addr[1:0];
                lane_wdata = {4{mem_q.sdata[7:0]}};
            end
            default: begin
                lane_be    = 4'b0000;
                lane_wdata = mem_q.sdata;
            end
        endcase
    end

    // Gating on hold means a stalled store hits memory only on the edge it leaves MEM.
    assign m_data_byteen = (mem_q.valid & ~misaligned & ~hold) ? lane_be : 4'b0000;
    assign m_data_addr   = mem_q.addr;
    assign m_data_wdata  = lane_wdata;
    assign m_inst_addr   = mem_q.pc;

    assign fwd_valid = mem_q.valid & mem_q.we & (mem_q.rd != 5'd0) & ~is_load(mem_q.mop);
    assign fwd_rd    = mem_q.rd;
    assign fwd_data  = mem_q.addr;

    load_ext u_load_ext (
        .word (wb_q.data),
        .off  (wb_q.off),
        .mop  (wb_q.mop),
        .data (ext_data)
    );

    assign w_grf_we    = wb_q.valid & wb_q.we & (wb_q.rd != 5'd0);
    assign w_grf_addr  = wb_q.rd;
    assign w_grf_wdata = ext_data;
    assign w_inst_addr = wb_q.pc;

    assign align_err = align_err_q;
    assign err_pc    = err_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q.valid <= 1'b0;
            mem_q.pc    <= RESET_PC;
            mem_q.mop   <= MOP_NONE;
            mem_q.addr  <= 32'h0;
            mem_q.sdata <= 32'h0;
            mem_q.rd    <= 5'd0;
            mem_q.we    <= 1'b0;
            wb_q.valid  <= 1'b0;
            wb_q.pc     <= RESET_PC;
            wb_q.mop    <= MOP_NONE;
            wb_q.off    <= 2'b00;
            wb_q.data   <= 32'h0;
            wb_q.rd     <= 5'd0;
            wb_q.we     <= 1'b0;
            align_err_q <= 1'b0;
            err_pc_q    <= 32'h0;
        end else begin
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            align_err_q <= align_err_d;
            err_pc_q    <= err_pc_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-addressed bus memory, transaction-level reference
// model (expected bus writes, writebacks, alignment errors), directed and random stimulus.
module tb_mem_stage_lsu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_mop;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        hold;
    logic        flush;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        align_err;
    logic [31:0] err_pc;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_mop        (ex_mop),
        .ex_addr       (ex_addr),
        .ex_sdata      (ex_sdata),
        .ex_rd         (ex_rd),
        .ex_we         (ex_we),
        .hold          (hold),
        .flush         (flush),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .align_err     (align_err),
        .err_pc        (err_pc),
        .w_grf_we      (w_grf_we),
        .w_grf_addr    (w_grf_addr),
        .w_grf_wdata   (w_grf_wdata),
        .w_inst_addr   (w_inst_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Bus memory (the environment the LSU talks to): 256 bytes, little-endian lanes.
    logic [7:0] bm [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) bm[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_data_byteen[i]) bm[{m_data_addr[7:2], i[1:0]}] <= m_data_wdata[8*i +: 8];
        end
    end
    assign m_data_rdata = {bm[{m_data_addr[7:2], 2'd3}], bm[{m_data_addr[7:2], 2'd2}],
                           bm[{m_data_addr[7:2], 2'd1}], bm[{m_data_addr[7:2], 2'd0}]};

    // Reference model: every accepted instruction becomes a list of expected events.
    typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] data;} bus_ev_t;
    typedef struct {logic [4:0] rd; logic [31:0] data; logic [31:0] pc;} wb_ev_t;
    bus_ev_t     bus_q[$];
    wb_ev_t      wb_q[$];
    logic [31:0] err_q[$];
    logic [7:0]  rm [256];
    logic        slot_valid, slot_we;
    logic [4:0]  slot_rd;
    logic [3:0]  slot_mop;
    logic [31:0] slot_pc, slot_addr;

    function automatic logic f_load(input logic [3:0] m);
        return (m == MOP_LW) || (m == MOP_LH) || (m == MOP_LHU) || (m == MOP_LB) || (m == MOP_LBU);
    endfunction

    function automatic logic f_store(input logic [3:0] m);
        return (m == MOP_SW) || (m == MOP_SH) || (m == MOP_SB);
    endfunction

    function automatic int f_size(input logic [3:0] m);
        if (m == MOP_LW || m == MOP_SW) return 4;
        if (m == MOP_LH || m == MOP_LHU || m == MOP_SH) return 2;
        return 1;
    endfunction

    function automatic logic f_misal(input logic [3:0] m, input logic [31:0] a);
        if (!f_load(m) && !f_store(m)) return 1'b0;
        return (a % f_size(m)) != 0;
    endfunction

    function automatic logic [31:0] f_loadval(input logic [3:0] m, input logic [7:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = rm[a];
        b1 = rm[a + 8'd1];
        b2 = rm[a + 8'd2];
        b3 = rm[a + 8'd3];
        case (m)
            MOP_LW:  return {b3, b2, b1, b0};
            MOP_LH:  return {{16{b1[7]}}, b1, b0};
            MOP_LHU: return {16'h0000, b1, b0};
            MOP_LB:  return {{24{b0[7]}}, b0};
            default: return {24'h000000, b0};
        endcase
    endfunction

    function automatic bus_ev_t f_bus(input logic [3:0] m, input logic [31:0] a, input logic [31:0] s);
        bus_ev_t e;
        e.addr = a;
        if (m == MOP_SW) begin
            e.be = 4'hF; e.data = s;
        end else if (m == MOP_SH) begin
            e.be = (a % 4 == 0) ? 4'b0011 : 4'b1100; e.data = {s[15:0], s[15:0]};
        end else begin
            e.be = 4'b0001 << (a % 4); e.data = {s[7:0], s[7:0], s[7:0], s[7:0]};
        end
        return e;
    endfunction

    function automatic wb_ev_t f_wb(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
        wb_ev_t e;
        e.rd = rd; e.data = d; e.pc = pc;
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bus_q.delete();
            wb_q.delete();
            err_q.delete();
            slot_valid <= 1'b0;
            for (int i = 0; i < 256; i++) rm[i] <= 8'h00;
        end else if (!hold) begin
            slot_valid <= ex_valid && !flush;
            slot_we    <= ex_we;
            slot_rd    <= ex_rd;
            slot_mop   <= ex_mop;
            slot_pc    <= ex_pc;
            slot_addr  <= ex_addr;
            if (ex_valid && !flush) begin
                if (f_misal(ex_mop, ex_addr)) begin
                    err_q.push_back(ex_pc);
                end else begin
                    if (f_store(ex_mop)) begin
                        bus_q.push_back(f_bus(ex_mop, ex_addr, ex_sdata));
                        for (int i = 0; i < f_size(ex_mop); i++)
                            rm[ex_addr[7:0] + 8'(i)] <= ex_sdata[8*i +: 8];
                    end
                    if (ex_we && ex_rd != 5'd0)
                        wb_q.push_back(f_wb(ex_rd,
                            f_load(ex_mop) ? f_loadval(ex_mop, ex_addr[7:0]) : ex_addr, ex_pc));
                end
            end
        end
    end

    // Compare process: outputs are checked mid-cycle against the model's event lists.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold) chk("byteen_hold", 32'(m_data_byteen), 32'h0);
            if (m_data_byteen != 4'h0) begin
                if (bus_q.size() == 0) chk("bus_unexpected", 32'(m_data_byteen), 32'h0);
                else begin
                    $display("*%h <= %h", m_data_addr, m_data_wdata);
                    chk("bus_addr", m_data_addr, bus_q[0].addr);
                    chk("bus_be", 32'(m_data_byteen), 32'(bus_q[0].be));
                    chk("bus_wdata", m_data_wdata, bus_q[0].data);
                    bus_q.delete(0);
                end
            end
            if (w_grf_we) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 32'(w_grf_we), 32'h0);
                else begin
                    $display("@%h: $%0d <= %h", w_inst_addr, w_grf_addr, w_grf_wdata);
                    chk("wb_rd", 32'(w_grf_addr), 32'(wb_q[0].rd));
                    chk("wb_data", w_grf_wdata, wb_q[0].data);
                    chk("wb_pc", w_inst_addr, wb_q[0].pc);
                    wb_q.delete(0);
                end
            end
            if (align_err) begin
                if (err_q.size() == 0) chk("err_unexpected", 32'(align_err), 32'h0);
                else begin
                    chk("err_pc", err_pc, err_q[0]);
                    err_q.delete(0);
                end
            end
            chk("fwd_valid", 32'(fwd_valid),
                32'(slot_valid && slot_we && slot_rd != 5'd0 && !f_load(slot_mop)));
            if (slot_valid && slot_we && slot_rd != 5'd0 && !f_load(slot_mop)) begin
                chk("fwd_rd", 32'(fwd_rd), 32'(slot_rd));
                chk("fwd_data", fwd_data, slot_addr);
            end
            if (slot_valid) begin
                chk("m_inst_addr", m_inst_addr, slot_pc);
                chk("m_data_addr", m_data_addr, slot_addr);
            end
        end
    end

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [3:0] mop,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic we, input logic h, input logic f);
        ex_valid = v; ex_pc = pc; ex_mop = mop; ex_addr = addr; ex_sdata = sd;
        ex_rd = rd; ex_we = we; hold = h; flush = f;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, MOP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        chk("rst_m_inst_addr", m_inst_addr, 32'h0000_3000);
        chk("rst_w_inst_addr", w_inst_addr, 32'h0000_3000);
        chk("rst_byteen", 32'(m_data_byteen), 32'h0);
        chk("rst_grf_we", 32'(w_grf_we), 32'h0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);
        chk("rst_err_pc", err_pc, 32'h0);
        chk("rst_m_data_addr", m_data_addr, 32'h0);
        chk("rst_grf_wdata", w_grf_wdata, 32'h0);
        reset = 1'b0;
        tick();

        // SW word write, no GRF write afterwards
        set_in(1'b1, 32'h3000, MOP_SW, 32'h8, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("sw_byteen", 32'(m_data_byteen), 32'hF);
        chk("sw_wdata", m_data_wdata, 32'h1234_5678);
        tick();
        chk("sw_no_wb", 32'(w_grf_we), 32'h0);

        // SB to 0xB then LB/LBU back
        set_in(1'b1, 32'h3004, MOP_SB, 32'hB, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h3008, MOP_LB, 32'hB, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("sb_byteen", 32'(m_data_byteen), 32'h8);
        chk("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
        tick();
        set_in(1'b1, 32'h300C, MOP_LBU, 32'hB, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("lb_we", 32'(w_grf_we), 32'h1);
        chk("lb_rd", 32'(w_grf_addr), 32'd5);
        chk("lb_data", w_grf_wdata, 32'hFFFF_FFAB);
        tick();
        chk("lbu_data", w_grf_wdata, 32'h0000_00AB);

        // SH to 0x6 then LH/LHU back
        set_in(1'b1, 32'h3014, MOP_SH, 32'h6, 32'h8001, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h3018, MOP_LH, 32'h6, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("sh_byteen", 32'(m_data_byteen), 32'hC);
        chk("sh_wdata", m_data_wdata, 32'h8001_8001);
        tick();
        set_in(1'b1, 32'h301C, MOP_LHU, 32'h6, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("lh_data", w_grf_wdata, 32'hFFFF_8001);
        tick();
        chk("lhu_data", w_grf_wdata, 32'h0000_8001);

        // misaligned LW
        set_in(1'b1, 32'h3010, MOP_LW, 32'h2, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        chk("mis_byteen", 32'(m_data_byteen), 32'h0);
        chk("mis_err_early", 32'(align_err), 32'h0);
        tick();
        chk("mis_err", 32'(align_err), 32'h1);
        chk("mis_err_pc", err_pc, 32'h3010);
        chk("mis_no_wb", 32'(w_grf_we), 32'h0);
        tick();
        chk("mis_err_pulse", 32'(align_err), 32'h0);
        chk("mis_err_pc_kept", err_pc, 32'h3010);

        // hold for 3 cycles (with flush) on a store behind an ALU op
        set_in(1'b1, 32'h3020, MOP_NONE, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h3024, MOP_SW, 32'h10, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int h = 0; h < 3; h++) begin
            set_in(1'b1, 32'h3028, MOP_LW, 32'h20, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1);
            chk("hold_byteen", 32'(m_data_byteen), 32'h0);
            chk("hold_m_inst_addr", m_inst_addr, 32'h3024);
            if (h == 0) chk("hold_alu_wb", w_grf_wdata, 32'h55);
            else chk("hold_bubble", 32'(w_grf_we), 32'h0);
            tick();
        end
        idle();
        chk("hold_bubble3", 32'(w_grf_we), 32'h0);
        chk("hold_bubble_pc", w_inst_addr, 32'h0000_3000);
        chk("hold_release_be", 32'(m_data_byteen), 32'hF);
        chk("hold_release_addr", m_data_addr, 32'h10);
        tick();
        chk("hold_mem_word", {bm[8'h13], bm[8'h12], bm[8'h11], bm[8'h10]}, 32'hCAFE_F00D);

        // reset while a load sits in MEM
        set_in(1'b1, 32'h3030, MOP_LW, 32'h8, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk("rst_mid_grf_we", 32'(w_grf_we), 32'h0);
        chk("rst_mid_byteen", 32'(m_data_byteen), 32'h0);
        chk("rst_mid_inst_addr", m_inst_addr, 32'h0000_3000);
        reset = 1'b0;
        tick();
        chk("rst_mid_no_wb1", 32'(w_grf_we), 32'h0);
        tick();
        chk("rst_mid_no_wb2", 32'(w_grf_we), 32'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [3:0]  mop;
            logic [31:0] addr;
            mop  = 4'($urandom_range(0, 8));
            addr = 32'($urandom_range(0, 255));
            if ($urandom % 4 != 0) begin
                if (mop == MOP_LW || mop == MOP_SW) addr[1:0] = 2'b00;
                else if (mop == MOP_LH || mop == MOP_LHU || mop == MOP_SH) addr[0] = 1'b0;
            end
            set_in(($urandom % 8) != 0, 32'h4000 + 32'(n) * 4, mop, addr, $urandom,
                   5'($urandom_range(0, 31)),
                   (mop == MOP_SW || mop == MOP_SH || mop == MOP_SB) ? 1'b0 : (($urandom % 4) != 0),
                   ($urandom % 7) == 0, ($urandom % 9) == 0);
            tick();
        end
        idle();
        repeat (4) tick();
        chk("bus_q_left", 32'(bus_q.size()), 32'h0);
        chk("wb_q_left", 32'(wb_q.size()), 32'h0);
        chk("err_q_left", 32'(err_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
